// File: rtl/branch_pkg.sv
// Shared definitions for EX-stage branch resolution: funct3 codes, redirect select,
// recovery FSM states and branch outcome helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_RST_VAL = 2'b01;

    typedef enum logic [1:0] {
        PC_SEL_KEEP   = 2'b00,
        PC_SEL_TARGET = 2'b01,
        PC_SEL_SEQ    = 2'b10
    } pc_sel_e;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_e;

    // funct3 010/011 have no conditional-branch meaning
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic less, input logic equal);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = equal;
            F3_BNE:           taken = ~equal;
            F3_BLT,  F3_BLTU: taken = less;
            F3_BGE,  F3_BGEU: taken = ~less;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters; combinational read for IF,
// clocked saturating update from EX. Reads return the pre-update value.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int unsigned ENTRIES = 32'(1) << IDX_W;

    logic [1:0] r_cnt [ENTRIES];

    assign rd_taken_o = r_cnt[rd_idx_i][1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_cnt[i] <= BHT_RST_VAL;
            end
        end else if (wr_en_i) begin
            if (wr_taken_i && (r_cnt[wr_idx_i] != 2'b11)) begin
                r_cnt[wr_idx_i] <= r_cnt[wr_idx_i] + 2'(1);
            end else if (!wr_taken_i && (r_cnt[wr_idx_i] != 2'b00)) begin
                r_cnt[wr_idx_i] <= r_cnt[wr_idx_i] - 2'(1);
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: outcome decode, mispredict redirect/flush with a
// one-cycle recovery state, BHT training and branch statistics.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_stall_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_jmp_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_pred_taken_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             br_unsigned_o,
    output logic [1:0]       pc_sel_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    state_e           r_state;
    state_e           w_state_nxt;
    pc_sel_e          w_pc_sel;
    logic             w_flush;
    logic             w_jmp;
    logic             w_br;
    logic             w_legal;
    logic             w_taken;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_bht_we;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             w_unused;

    // Only the index bits of either PC feed the BHT
    assign w_unused = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0],
                        ex_pc_i[31:BHT_IDX_W+2], ex_pc_i[1:0]};

    assign br_unsigned_o = ex_funct3_i[1];

    // A combined branch+jump encoding is handled as a jump
    assign w_jmp        = ex_is_jmp_i;
    assign w_br         = ex_is_br_i & ~ex_is_jmp_i;
    assign w_legal      = f3_legal(ex_funct3_i);
    assign w_taken      = w_jmp | (w_br & br_taken(ex_funct3_i, br_less_i, br_equal_i));
    assign w_resolve    = rst_ni & ex_valid_i & ~ex_stall_i & (w_br | w_jmp) & (r_state == NORMAL);
    assign w_mispredict = w_resolve & (w_taken != ex_pred_taken_i);
    assign w_bht_we     = w_resolve & w_br & w_legal;

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (if_pc_i[BHT_IDX_W+1:2]),
        .rd_taken_o (if_pred_taken_o),
        .wr_en_i    (w_bht_we),
        .wr_idx_i   (ex_pc_i[BHT_IDX_W+1:2]),
        .wr_taken_i (w_taken)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NORMAL:  if (w_mispredict) w_state_nxt = RECOVER;
            RECOVER: w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
    end

    // Zero-latency redirect; resolve is already masked outside NORMAL
    always_comb begin
        w_flush  = 1'b0;
        w_pc_sel = PC_SEL_KEEP;
        if (w_mispredict) begin
            w_flush  = 1'b1;
            w_pc_sel = w_taken ? PC_SEL_TARGET : PC_SEL_SEQ;
        end
    end

    assign flush_o  = w_flush;
    assign pc_sel_o = w_pc_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_bht_we) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed and random stimulus for branch_ctrl, checked against an operand-level
// reference model (real comparisons, integer BHT counters, a recovery flag).
module tb_branch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic        ex_valid_i;
    logic        ex_stall_i;
    logic        ex_is_br_i;
    logic        ex_is_jmp_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic        ex_pred_taken_i;
    logic        br_less_i;
    logic        br_equal_i;
    logic        br_unsigned_o;
    logic [1:0]  pc_sel_o;
    logic        flush_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    branch_ctrl #(.BHT_IDX_W(4), .CNT_W(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_stall_i      (ex_stall_i),
        .ex_is_br_i      (ex_is_br_i),
        .ex_is_jmp_i     (ex_is_jmp_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pc_i         (ex_pc_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .br_less_i       (br_less_i),
        .br_equal_i      (br_equal_i),
        .br_unsigned_o   (br_unsigned_o),
        .pc_sel_o        (pc_sel_o),
        .flush_o         (flush_o),
        .br_cnt_o        (br_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    int          m_bht [16];
    logic [31:0] m_br;
    logic [31:0] m_mp;
    bit          m_rec;
    logic [31:0] op_a;
    logic [31:0] op_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_br  = 0;
        m_mp  = 0;
        m_rec = 0;
    endtask

    // One EX cycle: drive, check combinational and counter outputs, advance the model
    task automatic cyc(input bit v, input bit st, input bit br, input bit jmp,
                       input logic [2:0] f3, input logic [31:0] pc, input bit pred,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ifpc, input string tag);
        bit is_jmp, is_br, legal, res, taken, mis;
        int idx;
        ex_valid_i      = v;
        ex_stall_i      = st;
        ex_is_br_i      = br;
        ex_is_jmp_i     = jmp;
        ex_funct3_i     = f3;
        ex_pc_i         = pc;
        ex_pred_taken_i = pred;
        br_equal_i      = (a == b);
        br_less_i       = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        if_pc_i         = ifpc;
        #2;
        is_jmp = jmp;
        is_br  = br && !jmp;
        legal  = !(f3 == 3'd2 || f3 == 3'd3);
        res    = v && !st && (is_br || is_jmp) && !m_rec;
        taken  = is_jmp ? 1'b1 : (is_br && ref_taken(f3, a, b));
        mis    = res && (taken != pred);
        chk({tag, ".flush"},  32'(flush_o), 32'(mis));
        chk({tag, ".pcsel"},  32'(pc_sel_o), mis ? (taken ? 32'd1 : 32'd2) : 32'd0);
        chk({tag, ".uns"},    32'(br_unsigned_o), 32'(f3[1]));
        chk({tag, ".pred"},   32'(if_pred_taken_o), 32'(m_bht[ifpc[5:2]] >= 2));
        chk({tag, ".brcnt"},  br_cnt_o, m_br);
        chk({tag, ".mpcnt"},  mispred_cnt_o, m_mp);
        @(posedge clk_i);
        #1;
        idx = int'(pc[5:2]);
        if (res && is_br && legal) begin
            m_br++;
            if (taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (mis) m_mp++;
        m_rec = mis;
    endtask

    task automatic idle(input logic [31:0] ifpc, input string tag);
        cyc(0, 0, 0, 0, 3'd0, 32'h0, 0, 0, 0, ifpc, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_ni = 1'b0;
        ex_valid_i = 1; ex_stall_i = 0; ex_is_br_i = 1; ex_is_jmp_i = 0;
        ex_funct3_i = 3'd6; ex_pc_i = 32'h100; ex_pred_taken_i = 0;
        br_less_i = 1; br_equal_i = 1; if_pc_i = 32'h100;
        #12;
        chk("rst.flush", 32'(flush_o), 0);
        chk("rst.pcsel", 32'(pc_sel_o), 0);
        chk("rst.pred",  32'(if_pred_taken_o), 0);
        chk("rst.uns",   32'(br_unsigned_o), 1);
        chk("rst.brcnt", br_cnt_o, 0);
        chk("rst.mpcnt", mispred_cnt_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // BEQ taken, predicted not-taken; IF reads same entry during update
        cyc(1, 0, 1, 0, 3'd0, 32'h100, 0, 5, 5, 32'h100, "beq_mis");
        idle(32'h100, "beq_after");
        chk("beq.pred_now_taken", 32'(if_pred_taken_o), 1);
        chk("beq.brcnt", br_cnt_o, 1);
        chk("beq.mpcnt", mispred_cnt_o, 1);

        // BLTU not-taken twice: 01 -> 00 -> 00
        cyc(1, 0, 1, 0, 3'd6, 32'h104, 0, 9, 3, 32'h104, "bltu_nt1");
        cyc(1, 0, 1, 0, 3'd6, 32'h104, 0, 9, 3, 32'h104, "bltu_nt2");
        idle(32'h104, "bltu_after");

        // Mispredict then a live branch in the RECOVER bubble
        cyc(1, 0, 1, 0, 3'd0, 32'h108, 0, 7, 7, 32'h108, "rec_mis");
        cyc(1, 0, 1, 0, 3'd1, 32'h10c, 0, 1, 2, 32'h10c, "rec_bubble");
        cyc(1, 0, 1, 0, 3'd1, 32'h10c, 0, 1, 2, 32'h10c, "rec_back");
        idle(32'h10c, "rec_idle");

        // Taken BNE held for three cycles, then released
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 3'd1, 32'h110, 1, 1, 2, 32'h110, "stall_hold");
        cyc(1, 0, 1, 0, 3'd1, 32'h110, 1, 1, 2, 32'h110, "stall_drop");
        idle(32'h110, "stall_idle");

        // JAL mispredict, then illegal funct3
        cyc(1, 0, 0, 1, 3'd0, 32'h114, 0, 1, 2, 32'h114, "jal");
        idle(32'h114, "jal_idle");
        cyc(1, 0, 1, 0, 3'd2, 32'h118, 0, 5, 5, 32'h118, "illegal");
        cyc(1, 0, 1, 1, 3'd0, 32'h11c, 1, 1, 2, 32'h11c, "br_and_jmp");

        // Saturation to 11 with a read of the same index during the fifth update
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 3'd0, 32'h140, 1, 3, 3, 32'h200, "sat");
        cyc(1, 0, 1, 0, 3'd0, 32'h140, 1, 3, 3, 32'h140, "sat5");
        idle(32'h140, "sat_idle");
        chk("sat.pred", 32'(if_pred_taken_o), 1);

        // Asynchronous reset while a flush is being driven
        ex_valid_i = 1; ex_stall_i = 0; ex_is_br_i = 1; ex_is_jmp_i = 0;
        ex_funct3_i = 3'd0; ex_pc_i = 32'h140; ex_pred_taken_i = 0;
        br_equal_i = 1; br_less_i = 0; if_pc_i = 32'h140;
        #2;
        chk("midrst.flush_before", 32'(flush_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("midrst.flush", 32'(flush_o), 0);
        chk("midrst.pcsel", 32'(pc_sel_o), 0);
        chk("midrst.pred",  32'(if_pred_taken_o), 0);
        chk("midrst.brcnt", br_cnt_o, 0);
        chk("midrst.mpcnt", mispred_cnt_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(32'h140, "post_rst");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit v, st, br, jmp, pred;
            int kind;
            logic [2:0]  f3;
            logic [31:0] pc, ifpc;
            v    = $urandom_range(0, 3) != 0;
            st   = $urandom_range(0, 4) == 0;
            kind = int'($urandom_range(0, 9));
            br   = (kind <= 6) || (kind == 8);
            jmp  = (kind == 7) || (kind == 8);
            f3   = 3'($urandom_range(0, 7));
            pred = 1'($urandom_range(0, 1));
            pc   = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            ifpc = ($urandom_range(0, 1) == 1) ? pc
                 : (($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2));
            op_a = $urandom;
            case ($urandom_range(0, 2))
                0:       op_b = op_a;
                1:       op_b = op_a ^ 32'h8000_0000;
                default: op_b = $urandom;
            endcase
            cyc(v, st, br, jmp, f3, pc, pred, op_a, op_b, ifpc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
